// File: rtl/scrambler_pcie_pkg.sv
// Shared symbols, FSM states and interval type for the SKP scheduler.
package scrambler_pcie_pkg;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam logic [7:0] SKP_SYM = 8'h1C;
    localparam logic [7:0] IDL_SYM = 8'h00;

    typedef logic [11:0] interval_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_SKP  = 2'd2
    } state_t;

endpackage

// File: rtl/skp_scheduler_if.sv
// Upstream byte stream and scrambler-facing symbol bus.
interface skp_scheduler_if;

    logic [7:0] in_data;
    logic       in_k;
    logic       in_valid;
    logic       in_sop;
    logic       in_eop;
    logic       in_ready;

    logic [7:0] out_data;
    logic       out_k;
    logic       out_dis_scrambler;

    modport master (
        output in_data, in_k, in_valid, in_sop, in_eop,
        input  in_ready,
        input  out_data, out_k, out_dis_scrambler
    );

    modport slave (
        input  in_data, in_k, in_valid, in_sop, in_eop,
        output in_ready,
        output out_data, out_k, out_dis_scrambler
    );

endinterface

// File: rtl/skp_interval_timer.sv
// Free-running SKP interval counter with a sticky pending request.
module skp_interval_timer
    import scrambler_pcie_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  interval_t interval,
    input  logic      clr,
    output logic      pending,
    output logic      overflow
);

    interval_t count;
    logic      wrap;

    // >= lets a shrunk interval wrap on the very next compare
    assign wrap = (interval != '0) && (count >= interval - 12'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (interval == '0 || wrap)
                count <= '0;
            else
                count <= count + 12'd1;
            overflow <= wrap & pending & ~clr;
            if (wrap)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/skp_scheduler.sv
// Merges packet bytes with periodic COM+3xSKP ordered sets between packets.
module skp_scheduler
    import scrambler_pcie_pkg::*;
#(
    parameter logic [7:0] COM = COM_SYM,
    parameter logic [7:0] SKP = SKP_SYM,
    parameter logic [7:0] IDL = IDL_SYM
) (
    input  logic              clk,
    input  logic              rst,
    skp_scheduler_if.slave    bus,
    input  interval_t         cfg_skp_interval,
    input  logic              cfg_dis_scramble,
    output logic              skp_active,
    output logic              proto_err,
    output logic              skp_overflow
);

    state_t     state;
    state_t     state_n;
    logic [1:0] idx;
    logic [1:0] idx_n;
    logic       pending;
    logic       clr;
    logic       ready;
    logic [7:0] data_n;
    logic       k_n;
    logic       act_n;
    logic       perr_n;

    skp_interval_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .interval (cfg_skp_interval),
        .clr      (clr),
        .pending  (pending),
        .overflow (skp_overflow)
    );

    assign bus.in_ready = ready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = IDL;
        k_n     = 1'b0;
        act_n   = 1'b0;
        perr_n  = 1'b0;
        clr     = 1'b0;
        ready   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    data_n  = COM;
                    k_n     = 1'b1;
                    act_n   = 1'b1;
                    clr     = 1'b1;
                    state_n = ST_SKP;
                    idx_n   = 2'd1;
                end else begin
                    ready = ~rst;
                    if (bus.in_valid) begin
                        if (bus.in_sop) begin
                            data_n = bus.in_data;
                            k_n    = bus.in_k;
                            if (!bus.in_eop)
                                state_n = ST_PKT;
                        end else begin
                            perr_n = 1'b1;
                        end
                    end
                end
            end
            ST_PKT: begin
                // SKP is never inserted mid-packet
                ready = ~rst;
                if (bus.in_valid) begin
                    data_n = bus.in_data;
                    k_n    = bus.in_k;
                    if (bus.in_eop)
                        state_n = ST_IDLE;
                end
            end
            ST_SKP: begin
                data_n = SKP;
                k_n    = 1'b1;
                act_n  = 1'b1;
                if (idx == 2'd3) begin
                    state_n = ST_IDLE;
                    idx_n   = 2'd0;
                end else begin
                    idx_n = idx + 2'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= ST_IDLE;
            idx                   <= 2'd0;
            bus.out_data          <= IDL;
            bus.out_k             <= 1'b0;
            bus.out_dis_scrambler <= 1'b0;
            skp_active            <= 1'b0;
            proto_err             <= 1'b0;
        end else begin
            state                 <= state_n;
            idx                   <= idx_n;
            bus.out_data          <= data_n;
            bus.out_k             <= k_n;
            bus.out_dis_scrambler <= cfg_dis_scramble;
            skp_active            <= act_n;
            proto_err             <= perr_n;
        end
    end

endmodule

// File: tb/tb_skp_scheduler.sv
// Directed bench for skp_scheduler with a cycle model and literal checkpoints.
module tb_skp_scheduler;
    import scrambler_pcie_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    interval_t cfg = '0;
    logic      dis = 1'b0;
    logic      skp_active;
    logic      proto_err;
    logic      skp_overflow;

    skp_scheduler_if sif ();

    skp_scheduler u_dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (sif),
        .cfg_skp_interval (cfg),
        .cfg_dis_scramble (dis),
        .skp_active       (skp_active),
        .proto_err        (proto_err),
        .skp_overflow     (skp_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    int         m_cnt;
    int         m_skp_left;
    bit         m_pend;
    bit         m_pkt;
    logic [7:0] e_data;
    bit         e_k, e_dis, e_act, e_perr, e_ovf;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !rst && m_skp_left == 0 && (m_pkt || !m_pend);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_skp_left = 0; m_pend = 0; m_pkt = 0;
        e_data = 8'h00; e_k = 0; e_dis = 0;
        e_act = 0; e_perr = 0; e_ovf = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit clr;
        bit wrap;
        acc = sif.in_valid && m_ready();
        clr = 0;
        e_data = 8'h00; e_k = 0; e_act = 0; e_perr = 0;
        if (m_skp_left > 0) begin
            e_data = 8'h1C; e_k = 1; e_act = 1;
            m_skp_left--;
        end else if (m_pkt) begin
            if (acc) begin
                e_data = sif.in_data; e_k = sif.in_k;
                if (sif.in_eop) m_pkt = 0;
            end
        end else if (m_pend) begin
            e_data = 8'hBC; e_k = 1; e_act = 1;
            m_skp_left = 3; clr = 1;
        end else if (acc) begin
            if (sif.in_sop) begin
                e_data = sif.in_data; e_k = sif.in_k;
                m_pkt = !sif.in_eop;
            end else begin
                e_perr = 1;
            end
        end
        wrap = int'(cfg) != 0 && m_cnt + 1 >= int'(cfg);
        e_ovf = wrap && m_pend && !clr;
        if (wrap) m_pend = 1;
        else if (clr) m_pend = 0;
        if (wrap || int'(cfg) == 0) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        e_dis = dis;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("out_data", sif.out_data, e_data);
            chk("out_k", sif.out_k, e_k);
            chk("out_dis", sif.out_dis_scrambler, e_dis);
            chk("skp_active", skp_active, e_act);
            chk("proto_err", proto_err, e_perr);
            chk("skp_overflow", skp_overflow, e_ovf);
            chk("in_ready", sif.in_ready, m_ready());
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic drv(input bit v, input logic [7:0] d, input bit k,
                       input bit s, input bit e);
        sif.in_valid = v; sif.in_data = d; sif.in_k = k;
        sif.in_sop = s; sif.in_eop = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        drv(0, 8'h00, 0, 0, 0);
        #1;
        chk("rst_data", sif.out_data, 8'h00);
        chk("rst_k", sif.out_k, 1'b0);
        chk("rst_act", skp_active, 1'b0);
        chk("rst_ready", sif.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_sym(input string name, input logic [7:0] d,
                           input bit k);
        chk({name, "_data"}, sif.out_data, d);
        chk({name, "_k"}, sif.out_k, k);
    endtask

    int ovf_cnt;
    int com_cnt;
    bit is_com;
    bit is_skp;

    initial begin
        drv(0, 8'h00, 0, 0, 0);
        model_reset();
        run = 1'b1;

        // idle link, interval 16
        cfg = 12'd16;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            tick();
            is_com = (i - 1 == 16) || (i - 1 == 32);
            is_skp = (i - 1 >= 17 && i - 1 <= 19) ||
                     (i - 1 >= 33 && i - 1 <= 35);
            chk("idle_act", skp_active, is_com || is_skp);
            if (is_com) chk_sym("idle_com", 8'hBC, 1);
            if (is_skp) chk_sym("idle_skp", 8'h1C, 1);
        end

        // long packet, interval 8
        cfg = 12'd8;
        do_reset();
        ovf_cnt = 0;
        repeat (2) tick();
        for (int j = 0; j < 20; j++) begin
            drv(1, 8'h40 + 8'(j), 0, j == 0, j == 19);
            chk("pkt_ready", sif.in_ready, 1'b1);
            tick();
            chk_sym("pkt_byte", 8'h40 + 8'(j), 0);
            ovf_cnt += int'(skp_overflow);
        end
        drv(0, 8'h00, 0, 0, 0);
        tick();
        chk_sym("post_com", 8'hBC, 1);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_sym("post_skp", 8'h1C, 1);
        end
        repeat (6) begin
            tick();
            ovf_cnt += int'(skp_overflow);
        end
        chk("ovf_count", ovf_cnt, 1);

        // COM clears pending on the same edge the interval wraps
        do_reset();
        repeat (2) tick();
        for (int j = 0; j < 13; j++) begin
            drv(1, 8'h60 + 8'(j), 0, j == 0, j == 12);
            tick();
        end
        drv(0, 8'h00, 0, 0, 0);
        tick();
        chk_sym("same_com", 8'hBC, 1);
        chk("same_ovf", skp_overflow, 1'b0);
        repeat (3) tick();
        tick();
        chk_sym("same_com2", 8'hBC, 1);

        // interval shrunk below current count
        cfg = 12'd16;
        do_reset();
        repeat (10) tick();
        cfg = 12'd5;
        tick();
        tick();
        chk_sym("shrink_com", 8'hBC, 1);

        // gap inside a packet, then a stray byte in IDLE
        cfg = 12'd0;
        do_reset();
        drv(1, 8'h10, 0, 1, 0); tick(); chk_sym("gap_b0", 8'h10, 0);
        drv(1, 8'hFB, 1, 0, 0); tick(); chk_sym("gap_b1", 8'hFB, 1);
        drv(0, 8'h00, 0, 0, 0); tick(); chk_sym("gap_i0", 8'h00, 0);
        tick(); chk_sym("gap_i1", 8'h00, 0);
        drv(1, 8'h12, 0, 0, 0); tick(); chk_sym("gap_b2", 8'h12, 0);
        drv(1, 8'h13, 0, 0, 1); tick(); chk_sym("gap_b3", 8'h13, 0);
        drv(1, 8'hA5, 0, 0, 0);
        chk("stray_ready", sif.in_ready, 1'b1);
        tick();
        chk_sym("stray", 8'h00, 0);
        chk("stray_perr", proto_err, 1'b1);
        drv(0, 8'h00, 0, 0, 0);
        tick();
        chk("stray_perr_end", proto_err, 1'b0);

        // reset during the second SKP
        cfg = 12'd16;
        do_reset();
        repeat (19) tick();
        chk_sym("pre_rst_skp", 8'h1C, 1);
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("rst_com", sif.out_data == 8'hBC && sif.out_k, i == 17);
        end

        // interval disabled with pending set, scramble toggles
        cfg = 12'd4;
        do_reset();
        com_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            drv(1, 8'h20 + 8'(i), 0, i == 1, i == 6);
            if (i == 3) begin
                dis = 1'b1;
                chk("dis_hold0", sif.out_dis_scrambler, 1'b0);
            end
            if (i == 5) begin
                dis = 1'b0;
                chk("dis_hold1", sif.out_dis_scrambler, 1'b1);
            end
            if (i == 6) cfg = 12'd0;
            tick();
            if (i == 3) chk("dis_on", sif.out_dis_scrambler, 1'b1);
            if (i == 5) chk("dis_off", sif.out_dis_scrambler, 1'b0);
        end
        drv(0, 8'h00, 0, 0, 0);
        repeat (34) begin
            tick();
            com_cnt += int'(sif.out_data == 8'hBC && sif.out_k);
        end
        chk("disabled_com_count", com_cnt, 1);

        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
